// File: rtl/svi_sdram_pkg.sv
// svi_sdram_pkg: shared types and constants for the SVI-328 SDRAM arbiter
package svi_sdram_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} arb_state_t;
  typedef enum logic [1:0] {REQ_DL, REQ_CPU, REQ_CAS} req_id_t;
  localparam int CAS_AGE_W = 8;
endpackage

// File: rtl/svi_sdram_prio.sv
// svi_sdram_prio: combinational winner select, dl > aged cas > cpu > cas
module svi_sdram_prio
  import svi_sdram_pkg::*;
(
  input  logic    dl_i,
  input  logic    cpu_i,
  input  logic    cas_i,
  input  logic    aged_i,
  output req_id_t id_o,
  output logic    valid_o
);
  // an aged cassette jumps ahead of the CPU but never ahead of download
  always_comb begin
    valid_o = dl_i | cpu_i | cas_i;
    id_o    = dl_i ? REQ_DL : (cas_i && aged_i) ? REQ_CAS : cpu_i ? REQ_CPU : REQ_CAS;
  end
endmodule

// File: rtl/svi_sdram_arbiter.sv
// svi_sdram_arbiter: shares the single SDRAM byte port among download, CPU and cassette
module svi_sdram_arbiter
  import svi_sdram_pkg::*;
#(
  parameter int                ADDR_W       = 20,
  parameter logic [ADDR_W-1:0] CAS_BASE     = 20'h40000,
  parameter int                CAS_MAX_WAIT = 64
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              dl_req_i,
  input  logic [ADDR_W-1:0] dl_addr_i,
  input  logic [7:0]        dl_din_i,
  output logic              dl_ack_o,
  output logic              dl_wait_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [17:0]       cpu_addr_i,
  input  logic [7:0]        cpu_din_i,
  output logic [7:0]        cpu_dout_o,
  output logic              cpu_ack_o,
  input  logic              cas_req_i,
  input  logic [17:0]       cas_addr_i,
  output logic [7:0]        cas_dout_o,
  output logic              cas_ack_o,
  output logic [ADDR_W-1:0] sdram_addr_o,
  output logic [7:0]        sdram_din_o,
  output logic              sdram_rd_o,
  output logic              sdram_we_o,
  input  logic [7:0]        sdram_dout_i,
  input  logic              sdram_ready_i
);
  arb_state_t             state_q, state_d;
  req_id_t                id_q, win_id;
  logic                   win_v, grant, done, we_q, dl_done_q, aged, cas_busy;
  logic                   win_we;
  logic [ADDR_W-1:0]      addr_q, win_addr;
  logic [7:0]             din_q, win_din, cpu_dout_q, cas_dout_q;
  logic [CAS_AGE_W-1:0]   cas_age_q, cas_age_d;

  svi_sdram_prio u_prio (
    .dl_i    (dl_req_i && !dl_done_q),
    .cpu_i   (cpu_req_i),
    .cas_i   (cas_req_i),
    .aged_i  (aged),
    .id_o    (win_id),
    .valid_o (win_v)
  );

  assign aged         = cas_age_q >= CAS_AGE_W'(CAS_MAX_WAIT);
  assign grant        = state_q == IDLE && sdram_ready_i && win_v;
  assign done         = state_q == WAIT && sdram_ready_i;
  assign cas_busy     = (grant && win_id == REQ_CAS) || (state_q != IDLE && id_q == REQ_CAS);
  assign dl_ack_o     = done && id_q == REQ_DL;
  assign cpu_ack_o    = done && id_q == REQ_CPU;
  assign cas_ack_o    = done && id_q == REQ_CAS;
  assign dl_wait_o    = dl_req_i && !dl_done_q;
  assign sdram_rd_o   = state_q == ISSUE && !we_q;
  assign sdram_we_o   = state_q == ISSUE && we_q;
  assign sdram_addr_o = addr_q;
  assign sdram_din_o  = din_q;
  assign cpu_dout_o   = cpu_dout_q;
  assign cas_dout_o   = cas_dout_q;

  // winner's command fields, cassette offset rebased into the tape region
  always_comb begin
    win_addr = win_id == REQ_DL ? dl_addr_i : win_id == REQ_CPU ? ADDR_W'(cpu_addr_i) : CAS_BASE + ADDR_W'(cas_addr_i);
    win_din  = win_id == REQ_DL ? dl_din_i : cpu_din_i;
    win_we   = win_id == REQ_DL || (win_id == REQ_CPU && cpu_we_i);
    cas_age_d = (!cas_req_i || cas_busy) ? '0 : (&cas_age_q) ? cas_age_q : cas_age_q + 1'b1;
  end

  // command sequencing; GUARD skips the controller's late ready drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = grant ? ISSUE : IDLE;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      default: state_d = sdram_ready_i ? IDLE : WAIT;
    endcase
  end

  // state, latched command, read data, aging and download-done registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      id_q       <= REQ_DL;
      addr_q     <= '0;
      din_q      <= '0;
      we_q       <= 1'b0;
      cpu_dout_q <= '0;
      cas_dout_q <= '0;
      cas_age_q  <= '0;
      dl_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cas_age_q <= cas_age_d;
      dl_done_q <= dl_req_i && (dl_done_q || dl_ack_o);
      if (grant) begin
        id_q   <= win_id;
        addr_q <= win_addr;
        din_q  <= win_din;
        we_q   <= win_we;
      end
      if (cpu_ack_o && !we_q) cpu_dout_q <= sdram_dout_i;
      if (cas_ack_o) cas_dout_q <= sdram_dout_i;
    end
  end
endmodule

// File: tb/tb_svi_sdram_arbiter.sv
// tb_svi_sdram_arbiter: directed checks of the SDRAM arbiter against a small controller model
module tb_svi_sdram_arbiter;
  logic        clk = 0, reset_n = 0;
  logic        dl_req = 0, cpu_req = 0, cpu_we = 0, cas_req = 0;
  logic [19:0] dl_addr = 0;
  logic [7:0]  dl_din = 0, cpu_din = 0;
  logic [17:0] cpu_addr = 0, cas_addr = 0;
  logic        dl_ack, dl_wait, cpu_ack, cas_ack, sdram_rd, sdram_we, sdram_ready;
  logic [7:0]  cpu_dout, cas_dout, sdram_din, sdram_dout = 0;
  logic [19:0] sdram_addr;
  logic [3:0]  cnt = 0;
  int          lat = 2;
  logic        force_busy = 0;
  logic [19:0] wr_addr = 0;
  logic [7:0]  wr_data = 0;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  svi_sdram_arbiter dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_din_i(dl_din), .dl_ack_o(dl_ack), .dl_wait_o(dl_wait),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din),
    .cpu_dout_o(cpu_dout), .cpu_ack_o(cpu_ack),
    .cas_req_i(cas_req), .cas_addr_i(cas_addr), .cas_dout_o(cas_dout), .cas_ack_o(cas_ack),
    .sdram_addr_o(sdram_addr), .sdram_din_o(sdram_din), .sdram_rd_o(sdram_rd), .sdram_we_o(sdram_we),
    .sdram_dout_i(sdram_dout), .sdram_ready_i(sdram_ready)
  );

  function automatic logic [7:0] mem(input logic [19:0] a);
    return a[7:0] ^ 8'h91;
  endfunction

  assign sdram_ready = cnt == 0 && !force_busy;

  always @(posedge clk) begin
    if (sdram_rd || sdram_we) cnt <= 4'(lat);
    else if (cnt != 0) cnt <= cnt - 1;
    if (sdram_rd) sdram_dout <= mem(sdram_addr);
    if (sdram_we) begin
      wr_addr <= sdram_addr;
      wr_data <= sdram_din;
    end
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({dl_ack, cpu_ack, cas_ack, sdram_rd, sdram_we, dl_wait} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000", {dl_ack, cpu_ack, cas_ack, sdram_rd, sdram_we, dl_wait});
    end
    checks++;
    if ({cpu_dout, cas_dout, sdram_din} !== 24'h0) begin
      failures++; $display("FAIL reset_dout got=%h exp=0", {cpu_dout, cas_dout, sdram_din});
    end
    checks++;
    if (sdram_addr !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", sdram_addr); end
    checks++;
    if (dut.cas_age_q !== 8'd0) begin failures++; $display("FAIL reset_age got=%0d exp=0", dut.cas_age_q); end
    @(posedge clk); #1 reset_n = 1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_cpu_rw();
    int ack_at = 0, rd_n = 0;
    logic [19:0] rd_addr = '1;
    cpu_addr = 18'h01234; cpu_we = 0; cpu_req = 1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sdram_rd) begin rd_n++; rd_addr = sdram_addr; end
      if (cpu_ack) begin ack_at = i; break; end
    end
    @(posedge clk); #1 cpu_req = 0;
    checks++;
    if (ack_at != 5) begin failures++; $display("FAIL cpu_rd_latency got=%0d exp=5", ack_at); end
    checks++;
    if (rd_n != 1 || rd_addr !== 20'h01234) begin
      failures++; $display("FAIL cpu_rd_strobe got=%0d@%h exp=1@01234", rd_n, rd_addr);
    end
    checks++;
    if (cpu_dout !== 8'hA5) begin failures++; $display("FAIL cpu_rd_data got=%h exp=a5", cpu_dout); end
    cpu_addr = 18'h00300; cpu_din = 8'h3C; cpu_we = 1; cpu_req = 1;
    ack_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin ack_at = i; break; end
    end
    @(posedge clk); #1 cpu_req = 0; cpu_we = 0;
    checks++;
    if (ack_at == 0 || wr_addr !== 20'h00300 || wr_data !== 8'h3C || cpu_dout !== 8'hA5) begin
      failures++; $display("FAIL cpu_wr got=%h/%h/%h ack=%0d exp=00300/3c/a5", wr_addr, wr_data, cpu_dout, ack_at);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_priority();
    int order[3];
    int n = 0, dl_k = -10, cpu_strobe = -1;
    dl_addr = 20'h12345; dl_din = 8'h77; dl_req = 1;
    cpu_addr = 18'h00100; cpu_we = 0; cpu_req = 1;
    cas_addr = 18'h00020; cas_req = 1;
    @(negedge clk);
    checks++;
    if (dl_wait !== 1'b1) begin failures++; $display("FAIL dl_wait_rise got=%b exp=1", dl_wait); end
    for (int k = 0; k < 80 && n < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (k == dl_k + 1) begin
        checks++;
        if (dl_wait !== 1'b0) begin failures++; $display("FAIL dl_wait_fall got=%b exp=0", dl_wait); end
      end
      if (sdram_rd && cpu_strobe < 0 && dl_k >= 0) cpu_strobe = k;
      if (dl_ack) begin order[n] = 0; n++; dl_k = k; end
      if (cpu_ack) begin order[n] = 1; n++; end
      if (cas_ack) begin order[n] = 2; n++; end
      @(posedge clk); #1;
      if (cpu_ack) cpu_req = 0;
      if (cas_ack) cas_req = 0;
      if (k == dl_k + 1) dl_req = 0;
    end
    checks++;
    if (n != 3 || order[0] != 0 || order[1] != 1 || order[2] != 2) begin
      failures++; $display("FAIL prio_order got=n%0d %0d%0d%0d exp=n3 012", n, order[0], order[1], order[2]);
    end
    checks++;
    if (cpu_strobe != dl_k + 2) begin failures++; $display("FAIL b2b_issue got=%0d exp=%0d", cpu_strobe, dl_k + 2); end
    checks++;
    if (wr_addr !== 20'h12345 || wr_data !== 8'h77) begin
      failures++; $display("FAIL dl_write got=%h/%h exp=12345/77", wr_addr, wr_data);
    end
    dl_req = 0; cpu_req = 0; cas_req = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_cas_read();
    logic [7:0]  cpu_before = cpu_dout;
    logic [19:0] rd_addr = '1;
    int          acked = 0;
    cas_addr = 18'h00010; cas_req = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sdram_rd) rd_addr = sdram_addr;
      if (cas_ack) begin acked = 1; break; end
    end
    @(posedge clk); #1 cas_req = 0;
    checks++;
    if (acked != 1 || rd_addr !== 20'h40010) begin
      failures++; $display("FAIL cas_addr got=%h ack=%0d exp=40010", rd_addr, acked);
    end
    checks++;
    if (cas_dout !== mem(20'h40010) || cpu_dout !== cpu_before) begin
      failures++; $display("FAIL cas_dout got=%h/%h exp=%h/%h", cas_dout, cpu_dout, mem(20'h40010), cpu_before);
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_aging();
    int n_cpu = 0, acked = 0;
    logic [19:0] cas_rd = '1;
    cpu_addr = 18'h00200; cpu_we = 0; cpu_req = 1;
    cas_addr = 18'h00033; cas_req = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sdram_rd && dut.id_q == 2'd2) cas_rd = sdram_addr;
      if (cpu_ack) n_cpu++;
      if (cas_ack) begin acked = 1; break; end
    end
    @(posedge clk); #1 cas_req = 0; cpu_req = 0;
    checks++;
    if (acked != 1 || n_cpu != 13) begin failures++; $display("FAIL aging_cpu_count got=%0d ack=%0d exp=13", n_cpu, acked); end
    checks++;
    if (cas_rd !== 20'h40033 || cas_dout !== mem(20'h40033)) begin
      failures++; $display("FAIL aging_cas got=%h/%h exp=40033/%h", cas_rd, cas_dout, mem(20'h40033));
    end
    @(negedge clk);
    checks++;
    if (dut.cas_age_q !== 8'd0) begin failures++; $display("FAIL aging_clear got=%0d exp=0", dut.cas_age_q); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen = 0, early = 0, acked = 0;
    lat = 10;
    cpu_addr = 18'h00055; cpu_we = 0; cpu_req = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sdram_rd) seen = 1;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sdram_ready !== 1'b0 || dut.state_q != 2'd3) begin
      failures++; $display("FAIL mid_setup got=%b/%0d exp=0/3", sdram_ready, dut.state_q);
    end
    reset_n = 0; force_busy = 1;
    #1;
    checks++;
    if ({cpu_ack, sdram_rd, sdram_we, cpu_dout, cas_dout, sdram_din} !== 27'h0 || sdram_addr !== 20'h0) begin
      failures++; $display("FAIL mid_reset got=%b %h %h %h %h", {cpu_ack, sdram_rd, sdram_we}, cpu_dout, cas_dout, sdram_din, sdram_addr);
    end
    @(posedge clk); #1 reset_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (sdram_rd || sdram_we) early++;
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL mid_no_strobe got=%0d exp=0", early); end
    lat = 2; force_busy = 0;
    seen = 0;
    for (int i = 0; i < 40 && !acked; i++) begin
      @(negedge clk);
      if (sdram_rd) seen++;
      if (cpu_ack) acked = 1;
    end
    @(posedge clk); #1 cpu_req = 0;
    checks++;
    if (seen != 1 || acked != 1 || cpu_dout !== mem(20'h00055)) begin
      failures++; $display("FAIL mid_resume got=%0d/%0d/%h exp=1/1/%h", seen, acked, cpu_dout, mem(20'h00055));
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int seen = 0, acks = 0, strobes = 0;
    cpu_addr = 18'h00077; cpu_we = 0; cpu_req = 1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sdram_rd) seen = 1;
    end
    @(posedge clk); #1 cpu_req = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
      if (sdram_rd || sdram_we) strobes++;
    end
    checks++;
    if (seen != 1 || acks != 1 || strobes != 0) begin
      failures++; $display("FAIL drop_ack got=%0d/%0d/%0d exp=1/1/0", seen, acks, strobes);
    end
    checks++;
    if (cpu_dout !== 8'hE6 || dut.state_q != 2'd0) begin
      failures++; $display("FAIL drop_data got=%h/%0d exp=e6/0", cpu_dout, dut.state_q);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_priority();
    test_cas_read();
    test_aging();
    test_reset_mid();
    test_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/svi_sdram_arbiter.md
# svi_sdram_arbiter

Sequences and shares the single SDRAM byte port of the SVI-328 core among three requesters: OSD ROM/cartridge download, the Z80 RAM path (after the RAM mapper), and the cassette reader, whose tape image moves from block RAM into SDRAM. It sits between those requesters and the `sdram` controller. It issues exactly one command at a time, returns read data and a completion pulse to the winner, and drives the download wait signal.

## Interface
Parameters:
- `ADDR_W`, 20: SDRAM byte-address width.
- `CAS_BASE`, 20'h40000: SDRAM base of the tape image region; cassette offsets are added to it.
- `CAS_MAX_WAIT`, 64: pending cycles after which the cassette outranks the CPU. Range 1..255.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: system clock (42.666 MHz).
- `reset_n_i` in 1: asynchronous active-low reset.
- `dl_req_i` in 1: download write request, level, held until ack.
- `dl_addr_i` in ADDR_W: download byte address, absolute.
- `dl_din_i` in 8: download write data.
- `dl_ack_o` out 1: one-cycle completion pulse.
- `dl_wait_o` out 1: high while `dl_req_i` is high and the ack has not yet pulsed; drives ioctl_wait.
- `cpu_req_i` in 1: CPU access request, level, held until ack.
- `cpu_we_i` in 1: 1 = write, 0 = read.
- `cpu_addr_i` in 18: mapped RAM address, absolute.
- `cpu_din_i` in 8: write data.
- `cpu_dout_o` out 8: last CPU read data, held.
- `cpu_ack_o` out 1: one-cycle completion pulse.
- `cas_req_i` in 1: cassette read request, level, held until ack.
- `cas_addr_i` in 18: tape byte offset.
- `cas_dout_o` out 8: last tape read data, held.
- `cas_ack_o` out 1: one-cycle completion pulse.
- `sdram_addr_o` out ADDR_W: command address.
- `sdram_din_o` out 8: write data.
- `sdram_rd_o` out 1: read strobe, one cycle.
- `sdram_we_o` out 1: write strobe, one cycle.
- `sdram_dout_i` in 8: read data, valid when ready rises.
- `sdram_ready_i` in 1: high = controller idle / previous command complete.

## Operation
- FSM states: IDLE, ISSUE, GUARD, WAIT.
- IDLE:
  - If `sdram_ready_i` is 1 and any request is pending, pick a winner and latch its id, address, data and direction.
  - Priority: dl > cas (when aged) > cpu > cas.
  - Go to ISSUE.
- ISSUE: assert exactly one of `sdram_rd_o`/`sdram_we_o` for one cycle with the latched address and data. Go to GUARD.
- GUARD: one cycle; `sdram_ready_i` is ignored here because the controller drops it with latency. Go to WAIT.
- WAIT: on `sdram_ready_i` = 1:
  - For a read, capture `sdram_dout_i` into the winner's dout register.
  - Pulse the winner's ack.
  - Go to IDLE.
- Address formation:
  - dl: `dl_addr_i` as given.
  - cpu: zero-extend to ADDR_W.
  - cas: `CAS_BASE + cas_addr_i`, truncated to ADDR_W; wrap-around is not flagged.
- Cassette aging:
  - 8-bit counter `cas_age`, incremented each cycle that `cas_req_i` is high and the cassette is not granted; saturates at 255.
  - Cleared on cassette grant or when `cas_req_i` is low.
  - Aged means `cas_age >= CAS_MAX_WAIT`.
- Download writes only; `dl_*` never reads.
- A requester dropping req before its ack is a protocol violation. The latched command still completes and the ack still pulses.
- Only the granted requester's dout register changes. The other registers hold their value.

## Timing
- Reset values:
  - All acks, strobes and `dl_wait_o` are 0.
  - `cpu_dout_o`, `cas_dout_o`, `sdram_addr_o` and `sdram_din_o` are 0.
  - State is IDLE and `cas_age` is 0.
- Minimum latency from req sampled in IDLE to ack is 4 cycles, when ready returns high in the first WAIT cycle.
- Back-to-back grants: the ack cycle returns to IDLE, so the next command issues at ack+2 at the earliest.
- Simultaneous requests in IDLE resolve by priority in the same cycle. Losers keep waiting with no extra penalty.
- `sdram_addr_o`/`sdram_din_o` stay registered from ISSUE until the next grant.
- Reset mid-command returns to IDLE immediately. After reset, no command issues until `sdram_ready_i` is seen high in IDLE, so an in-flight controller cycle finishes harmlessly.
- `dl_wait_o` is combinational from `dl_req_i` and a pending flag, so it reacts in the request cycle.

## Structure
- Shared package `svi_sdram_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, GUARD, WAIT};
  - requester enum `req_id_t` {REQ_DL, REQ_CPU, REQ_CAS};
  - constant `CAS_AGE_W` = 8.
- One sub-module, `svi_sdram_prio`: a combinational winner select from {dl, cpu, cas, aged}, output `req_id_t` plus a valid bit. The FSM, latches and aging counter live in the top module.

## Test plan
- `cpu_req_i`=1, `cpu_we_i`=0, `cpu_addr_i`=18'h01234, SDRAM returns 8'hA5 with 2-cycle ready-low → `sdram_rd_o` pulses once with addr 20'h01234, `cpu_ack_o` pulses, `cpu_dout_o`=8'hA5.
- dl, cpu and cas all requested in the same cycle → grant order dl, cpu, cas (`cas_age` < 64). `dl_wait_o` falls the cycle after `dl_ack_o`.
- `cas_addr_i`=18'h00010 → `sdram_addr_o`=20'h40010, `cas_dout_o` updated, `cpu_dout_o` unchanged.
- CPU requests continuously while the cassette waits → cassette is granted at the first IDLE after `cas_age` reaches 64, then `cas_age` returns to 0.
- `reset_n_i` low during WAIT with `sdram_ready_i`=0 → outputs 0 at once. After release, no strobe issues until `sdram_ready_i`=1.
- `cpu_req_i` dropped in GUARD → command completes, `cpu_ack_o` pulses once, FSM returns to IDLE.
